// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream -> instruction-memory words, then core release.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LEN0, LEN1, DATA, CHK, DONE, ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    LEN0, LEN1, DATA, DONE, ERROR
  } state_t;
`endif

  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

  state_t              state_q, state_d;
  logic                in_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic                core_rst_q;
  logic                done_q;
  logic                error_q;
  logic [ADDR_W:0]     wc_q;
  logic [1:0]          idx_q;
  logic [31:0]         buf_q;
  logic [7:0]          len_lo_q;
  logic [15:0]         n_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q;
`endif

  logic                xfer;
  logic [15:0]         n_d;
  logic                last_w;
  logic                ready_d;

  assign xfer   = in_valid & in_ready_q;
  assign n_d    = {in_data, len_lo_q};
  assign last_w = (32'(wc_q) + 32'd1) == 32'(n_q);

  // Next-state decode for the load sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN0: if (xfer) state_d = LEN1;
      LEN1: begin
        if (xfer) begin
          if (n_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if (32'(n_d) > CAP) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer && idx_q == 2'd3 && last_w) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: if (xfer) state_d = (in_data == sum_q) ? DONE : ERROR;
`endif
      default: state_d = state_q;
    endcase
  end

  // Ready is registered from the next state so it is low in DONE/ERROR
  always_comb begin
    ready_d = 1'b0;
    case (state_d)
      LEN0, LEN1, DATA: ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHK:              ready_d = 1'b1;
`endif
      default:          ready_d = 1'b0;
    endcase
  end

  // Loader FSM state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LEN0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wc_q         <= '0;
      idx_q        <= '0;
      buf_q        <= '0;
      len_lo_q     <= '0;
      n_q          <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= ready_d;
      imem_we_q  <= 1'b0;
      done_q     <= (state_q == DONE);
      core_rst_q <= (state_q != DONE);
      error_q    <= (state_d == ERROR);
      if (xfer) begin
        case (state_q)
          LEN0: len_lo_q <= in_data;
          LEN1: n_q <= n_d;
          DATA: begin
            buf_q[{idx_q, 3'b000} +: 8] <= in_data;
            idx_q <= idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_q + in_data;
`endif
            if (idx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= wc_q[ADDR_W-1:0];
              imem_wdata_q <= {in_data, buf_q[23:0]};
              wc_q         <= wc_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, empty image, oversize header,
// gapped stream, mid-load reset and (when enabled) checksum.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, imem_we;
  logic [7:0]  in_data;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst, done, error;
  logic [10:0] word_count;

  logic        rst4, v4, rdy4, we4, crst4, done4, err4;
  logic [7:0]  d4;
  logic [3:0]  addr4;
  logic [31:0] wdata4;
  logic [4:0]  wc4;

  prog_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done),
    .error(error), .word_count(word_count)
  );

  prog_loader #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(v4), .in_data(d4),
    .in_ready(rdy4), .imem_we(we4), .imem_addr(addr4),
    .imem_wdata(wdata4), .core_rst(crst4), .done(done4),
    .error(err4), .word_count(wc4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          pulse_err = 0;
  int          w4_cnt = 0;
  logic        prev_we = 1'b0;

  // Write monitor: log every write, flag back-to-back strobes
  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      if (prev_we) pulse_err++;
    end
    prev_we = imem_we;
    if (we4) w4_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    int t = 0;
    v4 = 1'b1;
    d4 = b;
    while (!rdy4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy4) chk("ready4_timeout", 64'd0, 64'd1);
    @(negedge clk);
    v4 = 1'b0;
  endtask

  task automatic send_img(input logic [7:0] bytes[$], input bit gaps);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps && $urandom_range(0, 9) < 3) @(negedge clk);
      if (i >= 2) s = s + bytes[i];
      send(bytes[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    send(s);
`endif
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    rst4 = 1'b1; v4 = 1'b0; d4 = 8'h00;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready",    64'(in_ready),   64'd0);
    chk("rst_we",       64'(imem_we),    64'd0);
    chk("rst_addr",     64'(imem_addr),  64'd0);
    chk("rst_wdata",    64'(imem_wdata), 64'd0);
    chk("rst_core_rst", 64'(core_rst),   64'd1);
    chk("rst_done",     64'(done),       64'd0);
    chk("rst_error",    64'(error),      64'd0);
    chk("rst_wc",       64'(word_count), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Two-word image
    base = wa_q.size();
    send_img('{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
               8'h73, 8'h00, 8'h10, 8'h00}, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_nwrites", 64'(wa_q.size() - base), 64'd2);
    if (wa_q.size() - base == 2) begin
      chk("t1_a0", 64'(wa_q[base]),   64'd0);
      chk("t1_d0", 64'(wd_q[base]),   64'h00A00513);
      chk("t1_a1", 64'(wa_q[base+1]), 64'd1);
      chk("t1_d1", 64'(wd_q[base+1]), 64'h00100073);
    end
    chk("t1_wc",       64'(word_count), 64'd2);
    chk("t1_done",     64'(done),       64'd1);
    chk("t1_core_rst", 64'(core_rst),   64'd0);
    chk("t1_ready",    64'(in_ready),   64'd0);
    chk("t1_error",    64'(error),      64'd0);

    // Empty image: done exactly two cycles after the last header byte
    pulse_rst();
    base = wa_q.size();
    send(8'h00);
    send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    chk("t2_done_early", 64'(done), 64'd0);
    @(negedge clk);
    chk("t2_done",     64'(done),     64'd1);
    chk("t2_core_rst", 64'(core_rst), 64'd0);
    repeat (2) @(negedge clk);
    chk("t2_nwrites", 64'(wa_q.size() - base), 64'd0);

    // ADDR_W=4: N=16 fits, N=17 is rejected
    send4(8'h10);
    send4(8'h00);
    @(negedge clk);
    chk("t3_n16_error", 64'(err4), 64'd0);
    chk("t3_n16_ready", 64'(rdy4), 64'd1);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    w4_cnt = 0;
    send4(8'h11);
    send4(8'h00);
    repeat (2) @(negedge clk);
    chk("t3_error",    64'(err4),   64'd1);
    chk("t3_core_rst", 64'(crst4),  64'd1);
    chk("t3_ready",    64'(rdy4),   64'd0);
    chk("t3_done",     64'(done4),  64'd0);
    chk("t3_nwrites",  64'(w4_cnt), 64'd0);

    // Three-word image with random idle cycles
    pulse_rst();
    base = wa_q.size();
    send_img('{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88,
               8'h01, 8'h02, 8'h03, 8'h04}, 1'b1);
    repeat (3) @(negedge clk);
    chk("t4_nwrites", 64'(wa_q.size() - base), 64'd3);
    if (wa_q.size() - base == 3) begin
      chk("t4_a0", 64'(wa_q[base]),   64'd0);
      chk("t4_d0", 64'(wd_q[base]),   64'h44332211);
      chk("t4_a1", 64'(wa_q[base+1]), 64'd1);
      chk("t4_d1", 64'(wd_q[base+1]), 64'h88776655);
      chk("t4_a2", 64'(wa_q[base+2]), 64'd2);
      chk("t4_d2", 64'(wd_q[base+2]), 64'h04030201);
    end
    chk("t4_pulses", 64'(pulse_err),  64'd0);
    chk("t4_wc",     64'(word_count), 64'd3);
    chk("t4_done",   64'(done),       64'd1);

    // Reset after 6 payload bytes, then a clean 1-word image
    pulse_rst();
    send(8'h02); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h11); send(8'h22);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_wc_clr",   64'(word_count), 64'd0);
    chk("t5_core_rst", 64'(core_rst),   64'd1);
    @(negedge clk);
    base = wa_q.size();
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("t5_we",    64'(imem_we),    64'd1);
    chk("t5_addr",  64'(imem_addr),  64'd0);
    chk("t5_wdata", 64'(imem_wdata), 64'hDEADBEEF);
    chk("t5_wc",    64'(word_count), 64'd1);
`ifdef LOADER_CHECKSUM_EN
    send(8'h38);
`endif
    repeat (3) @(negedge clk);
    chk("t5_nwrites", 64'(wa_q.size() - base), 64'd1);
    chk("t5_done",    64'(done),               64'd1);

`ifdef LOADER_CHECKSUM_EN
    pulse_rst();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h0A);
    repeat (3) @(negedge clk);
    chk("t6_ok_done",  64'(done),  64'd1);
    chk("t6_ok_error", 64'(error), 64'd0);
    pulse_rst();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h0B);
    repeat (3) @(negedge clk);
    chk("t6_bad_error",    64'(error),    64'd1);
    chk("t6_bad_core_rst", 64'(core_rst), 64'd1);
    chk("t6_bad_done",     64'(done),     64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
